// File: rtl/ex_mem_stage_elastic.sv
// Elastic EX/MEM pipeline register: valid/ready handshake with a two-entry skid buffer,
// synchronous squash and a saturating back-pressure counter.
module ex_mem_stage_elastic #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned REG_ID_WIDTH   = 5,
  parameter int unsigned MEM_CTRL_WIDTH = 3,
  parameter int unsigned WB_CTRL_WIDTH  = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     target_in,
  input  logic                      branch_decision_in,
  input  logic [DATA_WIDTH-1:0]     alu_res_in,
  input  logic [DATA_WIDTH-1:0]     write_data_in,
  input  logic [REG_ID_WIDTH-1:0]   dest_in,
  input  logic [MEM_CTRL_WIDTH-1:0] mem_control_in,
  input  logic [WB_CTRL_WIDTH-1:0]  wb_control_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     target_out,
  output logic                      branch_decision_out,
  output logic [DATA_WIDTH-1:0]     alu_res_out,
  output logic [DATA_WIDTH-1:0]     write_data_out,
  output logic [REG_ID_WIDTH-1:0]   dest_out,
  output logic [MEM_CTRL_WIDTH-1:0] mem_control_out,
  output logic [WB_CTRL_WIDTH-1:0]  wb_control_out,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  localparam int unsigned PayloadWidth =
      3 * DATA_WIDTH + 1 + REG_ID_WIDTH + MEM_CTRL_WIDTH + WB_CTRL_WIDTH;

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e                    state_q, state_d;
  logic [PayloadWidth-1:0]   main_q, main_d;
  logic [PayloadWidth-1:0]   skid_q, skid_d;
  logic [PayloadWidth-1:0]   payload_in;
  logic [CNT_WIDTH-1:0]      stall_q, stall_d;
  logic [MEM_CTRL_WIDTH-1:0] main_mem;
  logic [WB_CTRL_WIDTH-1:0]  main_wb;
  logic                      accept;
  logic                      consume;

  assign payload_in = {target_in, branch_decision_in, alu_res_in, write_data_in, dest_in,
                       mem_control_in, wb_control_in};

  // in_ready is a function of registered state only, never of out_ready.
  assign in_ready  = reset & (state_q != StSkid);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  assign {target_out, branch_decision_out, alu_res_out, write_data_out, dest_out,
          main_mem, main_wb} = main_q;

  // Bubbles must never write memory or the register file.
  assign mem_control_out = out_valid ? main_mem : '0;
  assign wb_control_out  = out_valid ? main_wb  : '0;
  assign stall_count     = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = payload_in;
            state_d = StFull;
          end
        end
        StFull: begin
          if (accept && consume) begin
            main_d = payload_in;
          end else if (accept) begin
            skid_d  = payload_in;
            state_d = StSkid;
          end else if (consume) begin
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = StFull;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_elastic.sv
// Randomised scoreboard bench for ex_mem_stage_elastic; a two-deep FIFO model predicts
// every output on each falling edge.
module tb_ex_mem_stage_elastic;

  localparam int DW = 64;
  localparam int RW = 5;
  localparam int MW = 3;
  localparam int WW = 2;
  localparam int CW = 4;
  localparam int CntMax = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] target;
    logic          bd;
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [RW-1:0] dest;
    logic [MW-1:0] mem;
    logic [WW-1:0] wb;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  beat_t         in_b;
  beat_t         out_b;
  logic [DW-1:0] target_out, alu_res_out, write_data_out;
  logic          branch_decision_out;
  logic [RW-1:0] dest_out;
  logic [MW-1:0] mem_control_out;
  logic [WW-1:0] wb_control_out;
  logic [CW-1:0] stall_count;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    started = 1'b0;
  beat_t exp_q[$];
  beat_t last_main;
  int    exp_cnt;

  always #5 clk = ~clk;

  ex_mem_stage_elastic #(
    .DATA_WIDTH(DW), .REG_ID_WIDTH(RW), .MEM_CTRL_WIDTH(MW), .WB_CTRL_WIDTH(WW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .target_in          (in_b.target),
    .branch_decision_in (in_b.bd),
    .alu_res_in         (in_b.alu),
    .write_data_in      (in_b.wd),
    .dest_in            (in_b.dest),
    .mem_control_in     (in_b.mem),
    .wb_control_in      (in_b.wb),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .target_out         (target_out),
    .branch_decision_out(branch_decision_out),
    .alu_res_out        (alu_res_out),
    .write_data_out     (write_data_out),
    .dest_out           (dest_out),
    .mem_control_out    (mem_control_out),
    .wb_control_out     (wb_control_out),
    .stall_count        (stall_count)
  );

  assign out_b = {target_out, branch_decision_out, alu_res_out, write_data_out, dest_out,
                  mem_control_out, wb_control_out};

  function automatic void check(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.target = {$urandom, $urandom};
    b.bd     = 1'($urandom);
    b.alu    = {$urandom, $urandom};
    b.wd     = {$urandom, $urandom};
    b.dest   = RW'($urandom);
    b.mem    = MW'($urandom);
    b.wb     = WW'($urandom);
    return b;
  endfunction

  function automatic beat_t alu_beat(input logic [DW-1:0] v);
    beat_t b;
    b = rnd_beat();
    b.alu = v;
    return b;
  endfunction

  // Monitor + reference model: the stage behaves as a FIFO of depth two.
  always @(negedge clk) begin
    if (started) begin
      beat_t exp_out;
      bit    accept, consume;
      check("in_ready", 256'(in_ready), 256'(reset && exp_q.size() < 2));
      check("out_valid", 256'(out_valid), 256'(exp_q.size() > 0));
      check("stall_count", 256'(stall_count), 256'(exp_cnt));
      if (exp_q.size() > 0) begin
        exp_out = exp_q[0];
      end else begin
        exp_out     = last_main;
        exp_out.mem = '0;
        exp_out.wb  = '0;
      end
      check("payload", 256'(out_b), 256'(exp_out));

      if (!reset) begin
        exp_q.delete();
        last_main = '0;
        exp_cnt   = 0;
      end else begin
        consume = (exp_q.size() > 0) && out_ready;
        accept  = in_valid && (exp_q.size() < 2);
        if ((exp_q.size() > 0) && !out_ready && exp_cnt < CntMax) exp_cnt++;
        if (consume) void'(exp_q.pop_front());
        if (accept) exp_q.push_back(in_b);
        if (flush) exp_q.delete();
        if (exp_q.size() > 0) last_main = exp_q[0];
      end
    end
  end

  task automatic step(input logic rst_n, input logic iv, input logic fl, input logic ordy,
                      input beat_t b);
    @(posedge clk);
    #1;
    started   = 1'b1;
    reset     = rst_n;
    in_valid  = iv;
    flush     = fl;
    out_ready = ordy;
    in_b      = b;
  endtask

  initial begin
    beat_t b;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_b      = '0;
    last_main = '0;
    exp_cnt   = 0;

    // Reset for two cycles, then stream 1..4 with out_ready high.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, alu_beat(DW'(i)));
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, rnd_beat());

    // Back-pressure: A and B with out_ready low, then drain.
    step(1'b1, 1'b1, 1'b0, 1'b0, alu_beat(DW'('hA)));
    step(1'b1, 1'b1, 1'b0, 1'b0, alu_beat(DW'('hB)));
    step(1'b1, 1'b1, 1'b0, 1'b0, alu_beat(DW'('hC)));
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, rnd_beat());

    // Flush from SKID with a beat offered in the same cycle.
    step(1'b1, 1'b1, 1'b0, 1'b0, alu_beat(DW'('h11)));
    step(1'b1, 1'b1, 1'b0, 1'b0, alu_beat(DW'('h22)));
    step(1'b1, 1'b1, 1'b1, 1'b0, alu_beat(DW'('h33)));
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd_beat());

    // Bubble gating: controls presented with in_valid low.
    b = rnd_beat();
    b.mem = 3'b001;
    b.wb  = 2'b10;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, b);

    // Saturation: one beat held for 20 cycles.
    step(1'b1, 1'b1, 1'b0, 1'b0, alu_beat(DW'('h55)));
    repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0, rnd_beat());
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd_beat());

    // Reset while in SKID, then a single beat.
    step(1'b1, 1'b1, 1'b0, 1'b0, alu_beat(DW'('h66)));
    step(1'b1, 1'b1, 1'b0, 1'b0, alu_beat(DW'('h77)));
    step(1'b0, 1'b1, 1'b1, 1'b0, alu_beat(DW'('h88)));
    step(1'b1, 1'b1, 1'b0, 1'b1, alu_beat(DW'('h99)));
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, rnd_beat());

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0), rnd_beat());
    end
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, rnd_beat());
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
